// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator divider slice: default widths tied to
// the MAC datapath, FSM state type and counter sizing helper.
package acc_pkg;

  localparam int unsigned ACC_DIVIDEND_W = 25;
  localparam int unsigned ACC_DIVISOR_W  = 12;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // Bits needed for a counter that must hold the value n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned ACC_CNT_W = cnt_w(ACC_DIVIDEND_W);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits and report the resulting quotient bit.
module div_step #(
  parameter int unsigned DIVISOR_W = acc_pkg::ACC_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  typedef logic [DIVISOR_W:0] rem_t;

  rem_t shifted;
  rem_t divisor_ext;

  // Partial remainder is always below the divisor, so dropping its MSB on the
  // shift loses nothing; the extra bit only protects the compare.
  always_comb begin
    shifted     = rem_t'({rem_i, bit_i});
    divisor_ext = {1'b0, divisor_i};
    if (shifted >= divisor_ext) begin
      rem_o = shifted - divisor_ext;
      q_o   = 1'b1;
    end else begin
      rem_o = shifted;
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/acc_divider.sv
// Sequential restoring divider for accumulated MAC results: one quotient bit
// per cycle, valid/ready on input and output, divide-by-zero flagged.
module acc_divider
  import acc_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = ACC_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = ACC_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = cnt_w(DIVIDEND_W);

  div_state_t            state_q, state_d;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DIVIDEND_W-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dq_q    <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept, iterate one step per cycle, hold the result.
  always_comb begin
    state_d = state_q;
    dq_d    = dq_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dq_d  = dividend;
          div_d = divisor;
          rem_d = '0;
          cnt_d = CNT_W'(DIVIDEND_W);
          dbz_d = 1'b0;
          if (divisor != '0) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            quo_d   = '1;
            remo_d  = '0;
            dbz_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        dq_d  = {dq_q[DIVIDEND_W-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quo_d   = {dq_q[DIVIDEND_W-2:0], step_q};
          remo_d  = step_rem[DIVISOR_W-1:0];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
